// File: rtl/pc_sequencer.sv
// Program-counter sequencer feeding an external return-address stack.
// Handles sequential fetch, jumps, calls and returns, and flags stack over/underflow.
module pc_sequencer #(
  parameter int              AW       = 12,
  parameter int              DEPTH    = 8,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          jmp,
  input  logic          jsr,
  input  logic          ret,
  input  logic [AW-1:0] target,
  input  logic [AW-1:0] stack_out,
  output logic [AW-1:0] pc,
  output logic          push,
  output logic          pop,
  output logic [AW-1:0] push_data,
  output logic [3:0]    depth,
  output logic          busy,
  output logic          err
);

  typedef enum logic [1:0] {RUN, RET_WAIT, ERR} state_t;

  localparam logic [3:0]    DEPTH_MAX = 4'(DEPTH);
  localparam logic [AW-1:0] ONE       = {{(AW-1){1'b0}}, 1'b1};

  state_t        state, state_nxt;
  logic [AW-1:0] pc_nxt;
  logic [3:0]    depth_nxt;
  logic          err_nxt;

  assign push_data = pc + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      pc    <= RESET_PC;
      depth <= 4'd0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      depth <= depth_nxt;
      err   <= err_nxt;
    end
  end

  // Stack handshakes are combinational so the stack sees push/pop in the same cycle as the command.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    depth_nxt = depth;
    err_nxt   = err;
    push      = 1'b0;
    pop       = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      unique case (state)
        RUN: begin
          if (en) begin
            if (ret) begin
              if (depth == 4'd0) begin
                err_nxt   = 1'b1;
                state_nxt = ERR;
              end else begin
                pop       = 1'b1;
                state_nxt = RET_WAIT;
              end
            end else if (jsr) begin
              if (depth == DEPTH_MAX) begin
                err_nxt   = 1'b1;
                state_nxt = ERR;
              end else begin
                push      = 1'b1;
                pc_nxt    = target;
                depth_nxt = depth + 4'd1;
              end
            end else if (jmp) begin
              pc_nxt = target;
            end else begin
              pc_nxt = push_data;
            end
          end
        end
        // The stack's registered output carries the popped address one cycle after the pop.
        RET_WAIT: begin
          busy      = 1'b1;
          pc_nxt    = stack_out;
          depth_nxt = depth - 4'd1;
          state_nxt = RUN;
        end
        ERR: begin
          state_nxt = ERR;
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a call/return reference model predicts every cycle,
// and a small behavioural return-address stack answers the DUT's push/pop requests.
module tb_pc_sequencer;

  localparam int AW    = 12;
  localparam int DEPTH = 8;
  localparam int MASK  = (1 << AW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          en, jmp, jsr, ret;
  logic [AW-1:0] target;
  logic [AW-1:0] stackOut;
  logic [AW-1:0] pc;
  logic          push, pop;
  logic [AW-1:0] push_data;
  logic [3:0]    depth;
  logic          busy, err;

  always #5 clk = ~clk;

  pc_sequencer #(.AW(AW), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .en(en), .jmp(jmp), .jsr(jsr), .ret(ret),
    .target(target), .stack_out(stackOut), .pc(pc), .push(push), .pop(pop),
    .push_data(push_data), .depth(depth), .busy(busy), .err(err)
  );

  // Behavioural stack: stores whatever the DUT pushes, presents popped data one cycle later.
  logic [AW-1:0] ras[$];
  initial stackOut = '0;
  always @(posedge clk) begin
    if (push) ras.push_back(push_data);
    if (pop && ras.size() > 0) stackOut <= ras.pop_back();
  end

  typedef struct {
    int    pushE;
    int    popE;
    int    busyE;
    int    pdE;
    int    pcE;
    int    depthE;
    int    errE;
    string tag;
  } exp_t;

  exp_t sb[$];
  int checks   = 0;
  int failures = 0;

  // Reference model: architectural PC, list of pending return addresses, error and return-pending flags.
  int mPc;
  int mErr;
  int mWait;
  int mStack[$];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit e, input bit j, input bit s, input bit r,
                               input int t, input string tag);
    exp_t x;
    @(posedge clk);
    #2;
    en = e; jmp = j; jsr = s; ret = r; target = AW'(t);
    x.pushE = 0; x.popE = 0; x.busyE = 0;
    x.pdE = (mPc + 1) & MASK;
    x.tag = tag;
    if (mErr != 0) begin
    end else if (mWait != 0) begin
      x.busyE = 1;
      mPc     = mStack.pop_back();
      mWait   = 0;
    end else if (e) begin
      if (r) begin
        if (mStack.size() == 0) mErr = 1;
        else begin
          x.popE = 1;
          mWait  = 1;
        end
      end else if (s) begin
        if (mStack.size() == DEPTH) mErr = 1;
        else begin
          x.pushE = 1;
          mStack.push_back((mPc + 1) & MASK);
          mPc = t & MASK;
        end
      end else if (j) begin
        mPc = t & MASK;
      end else begin
        mPc = (mPc + 1) & MASK;
      end
    end
    x.pcE    = mPc;
    x.depthE = mStack.size();
    x.errE   = mErr;
    sb.push_back(x);
  endtask

  task automatic doReset();
    @(posedge clk);
    #2;
    rst = 1'b1; en = 1'b0; jmp = 1'b0; jsr = 1'b0; ret = 1'b0; target = '0;
    #1;
    checkOutput("rst.pc", pc, 0);
    checkOutput("rst.depth", depth, 0);
    checkOutput("rst.err", err, 0);
    checkOutput("rst.push", push, 0);
    checkOutput("rst.pop", pop, 0);
    checkOutput("rst.busy", busy, 0);
    ras.delete();
    mStack.delete();
    mPc = 0; mErr = 0; mWait = 0;
    @(posedge clk);
    #2;
    rst = 1'b0;
  endtask

  // Monitor: combinational handshakes mid-cycle, registered state just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput({e.tag, ".push"}, push, e.pushE);
        checkOutput({e.tag, ".pop"}, pop, e.popE);
        checkOutput({e.tag, ".busy"}, busy, e.busyE);
        checkOutput({e.tag, ".push_data"}, push_data, e.pdE);
        @(posedge clk);
        #1;
        checkOutput({e.tag, ".pc"}, pc, e.pcE);
        checkOutput({e.tag, ".depth"}, depth, e.depthE);
        checkOutput({e.tag, ".err"}, err, e.errE);
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; en = 1'b0; jmp = 1'b0; jsr = 1'b0; ret = 1'b0; target = '0;
    mPc = 0; mErr = 0; mWait = 0;
    doReset();

    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 0, 0, "t1_idle");

    applyStimulus(1, 1, 0, 0, 'h010, "t2_jmp");
    applyStimulus(1, 0, 1, 0, 'h200, "t2_jsr");
    applyStimulus(1, 1, 0, 0, 'h205, "t3_jmp");
    applyStimulus(1, 0, 0, 1, 0, "t3_ret");
    applyStimulus(1, 0, 1, 0, 'h333, "t3_wait");
    applyStimulus(1, 0, 0, 0, 0, "t3_after");

    doReset();
    for (int i = 0; i < DEPTH; i++) applyStimulus(1, 0, 1, 0, 'h100 + i * 'h10, "t4_nest");
    applyStimulus(1, 0, 1, 0, 'h7AB, "t4_ovf");
    applyStimulus(1, 0, 0, 1, 0, "t4_frozen_ret");
    applyStimulus(0, 0, 0, 0, 0, "t4_frozen_off");
    applyStimulus(1, 1, 0, 0, 'h123, "t4_frozen_jmp");

    doReset();
    applyStimulus(1, 0, 0, 1, 0, "t5_unf");
    for (int i = 0; i < 4; i++) applyStimulus(i[0], 1, i[1], 0, 'h0AA, "t5_frozen");

    doReset();
    applyStimulus(1, 1, 0, 0, 'hFFF, "t6_jmp");
    applyStimulus(1, 0, 0, 0, 0, "t6_wrap");
    applyStimulus(1, 1, 0, 0, 'hFFF, "t6_jmp2");
    applyStimulus(1, 0, 1, 0, 'h050, "t6_jsr_wrap");
    applyStimulus(1, 0, 1, 1, 'h077, "t6_ret_jsr");
    applyStimulus(1, 0, 0, 0, 0, "t6_load");
    applyStimulus(1, 0, 0, 0, 0, "t6_seq");

    // Reset arriving while a return is waiting for its popped address.
    applyStimulus(1, 0, 1, 0, 'h300, "rw_jsr");
    applyStimulus(1, 0, 0, 1, 0, "rw_ret");
    doReset();
    applyStimulus(0, 0, 0, 0, 0, "rw_after");
    applyStimulus(1, 0, 0, 0, 0, "rw_seq");

    for (int n = 0; n < 1500; n++) begin
      int t;
      if (mErr != 0 && ($urandom % 4) == 0) doReset();
      t = ($urandom % 4 == 0) ? (MASK - int'($urandom % 3)) : int'($urandom & MASK);
      applyStimulus(($urandom % 8) != 0, ($urandom % 5) == 0, ($urandom % 3) == 0,
                    ($urandom % 7) == 0, t, "rand");
    end
    applyStimulus(0, 0, 0, 0, 0, "final");

    @(posedge clk);
    #4;
    checkOutput("sb_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
